// File: rtl/apb_master_bridge_if.sv
// Core data-port and APB3 bus signals of apb_master_bridge, bundled for port connection.
// master = bridge view, slave = core/peripheral environment view.
interface apb_master_bridge_if #(
    parameter int unsigned NUM_SLAVES = 4
);
    // core side
    logic                       transfer;
    logic                       write;
    logic [31:0]                addr;
    logic [31:0]                wdata;
    logic [31:0]                rdata;
    logic                       ready;
    logic                       err;

    // APB side; slave i drives PRDATA[32i+31:32i]
    logic [31:0]                PADDR;
    logic [31:0]                PWDATA;
    logic                       PWRITE;
    logic [NUM_SLAVES-1:0]      PSEL;
    logic                       PENABLE;
    logic [32*NUM_SLAVES-1:0]   PRDATA;
    logic [NUM_SLAVES-1:0]      PREADY;
    logic [NUM_SLAVES-1:0]      PSLVERR;

    modport master (
        input  transfer, write, addr, wdata, PRDATA, PREADY, PSLVERR,
        output rdata, ready, err, PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output transfer, write, addr, wdata, PRDATA, PREADY, PSLVERR,
        input  rdata, ready, err, PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Core data port to APB3 bridge: window decode, SETUP/ACCESS sequencing, wait-state stall, error return.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT cycles.
module apb_master_bridge #(
    parameter int unsigned NUM_SLAVES      = 4,
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
    parameter int unsigned SLAVE_SIZE_LOG2 = 12,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic                clk,
    input  logic                reset,
    apb_master_bridge_if.master bus
);

    localparam int unsigned IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned NS_W     = NUM_SLAVES;
    localparam logic [32:0] WIN_SIZE = 33'(NUM_SLAVES) << SLAVE_SIZE_LOG2;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("apb_master_bridge: NUM_SLAVES must be 1..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e            state_q,   state_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [31:0]       paddr_q,   paddr_d;
    logic [31:0]       pwdata_q,  pwdata_d;
    logic              pwrite_q,  pwrite_d;
    logic [NS_W-1:0]   psel_q,    psel_d;
    logic              penable_q, penable_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic              ready_q,   ready_d;
    logic              err_q,     err_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TO_W-1:0]   cnt_q,     cnt_d;
`endif

    // Window decode of the incoming core address
    logic [31:0]       offset_c;
    logic              in_range_c;
    logic [IDX_W-1:0]  idx_c;

    assign offset_c   = bus.addr - BASE_ADDR;
    assign in_range_c = (bus.addr >= BASE_ADDR) && ({1'b0, offset_c} < WIN_SIZE);
    assign idx_c      = IDX_W'(offset_c >> SLAVE_SIZE_LOG2);

    // Response of the currently addressed slave only
    logic              sel_pready_c;
    logic              sel_pslverr_c;
    logic [31:0]       sel_prdata_c;

    assign sel_pready_c  = bus.PREADY[idx_q];
    assign sel_pslverr_c = bus.PSLVERR[idx_q];
    assign sel_prdata_c  = bus.PRDATA[32*int'(idx_q) +: 32];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.transfer) begin
                    paddr_d  = bus.addr;
                    pwdata_d = bus.wdata;
                    pwrite_d = bus.write;
                    if (in_range_c) begin
                        idx_d   = idx_c;
                        psel_d  = NS_W'(1) << idx_c;
                        state_d = SETUP;
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end

            ACCESS: begin
                if (sel_pready_c) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                    ready_d   = 1'b1;
                    err_d     = sel_pslverr_c;
                    rdata_d   = pwrite_q ? 32'h0 : sel_prdata_c;
                end
`ifdef APB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + TO_W'(1);
                    // Limit reached on this cycle: abandon the slave and report an error
                    if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                        psel_d    = '0;
                        penable_d = 1'b0;
                        state_d   = IDLE;
                        ready_d   = 1'b1;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                    end
                end
`endif
            end

            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.rdata   = rdata_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (4 slaves, 4 KiB regions at 0x1000_0000, TIMEOUT = 4).
// Timeout steps are built only when APB_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    apb_master_bridge_if #(.NUM_SLAVES(4)) bus ();

    apb_master_bridge #(
        .NUM_SLAVES      (4),
        .BASE_ADDR       (32'h1000_0000),
        .SLAVE_SIZE_LOG2 (12),
        .TIMEOUT         (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; values are then observed 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prdata(input int i, input logic [31:0] v);
        bus.PRDATA[32*i +: 32] = v;
    endtask

    task automatic start(input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.transfer = 1'b1;
        bus.write    = wr;
        bus.addr     = a;
        bus.wdata    = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_psel"},    32'(bus.PSEL),    32'h0);
        check({tag, "_penable"}, 32'(bus.PENABLE), 32'h0);
        check({tag, "_ready"},   32'(bus.ready),   32'h0);
        check({tag, "_err"},     32'(bus.err),     32'h0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.transfer = 1'b0;
        bus.write    = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.PRDATA   = '0;
        bus.PREADY   = '0;
        bus.PSLVERR  = '0;
        set_prdata(0, 32'h1111_1111);
        set_prdata(1, 32'hDEAD_BEEF);
        set_prdata(2, 32'h55AA_55AA);
        set_prdata(3, 32'hCAFE_F00D);

        // ---- reset values
        tick();
        tick();
        check_idle_outputs("rst");
        check("rst_pwrite", 32'(bus.PWRITE), 32'h0);
        check("rst_paddr",  bus.PADDR,       32'h0);
        check("rst_pwdata", bus.PWDATA,      32'h0);
        check("rst_rdata",  bus.rdata,       32'h0);
        reset = 1'b0;
        tick();

        // ---- zero-wait read from slave 1
        bus.PREADY = 4'b0010;
        start(1'b0, 32'h1000_1004, 32'hAAAA_5555);
        tick();                                     // cycle 1: SETUP
        bus.transfer = 1'b0;
        check("rd_setup_psel",    32'(bus.PSEL),    32'h2);
        check("rd_setup_penable", 32'(bus.PENABLE), 32'h0);
        check("rd_setup_paddr",   bus.PADDR,        32'h1000_1004);
        check("rd_setup_pwrite",  32'(bus.PWRITE),  32'h0);
        check("rd_setup_ready",   32'(bus.ready),   32'h0);
        tick();                                     // cycle 2: ACCESS
        check("rd_acc_psel",    32'(bus.PSEL),    32'h2);
        check("rd_acc_penable", 32'(bus.PENABLE), 32'h1);
        check("rd_acc_ready",   32'(bus.ready),   32'h0);
        tick();                                     // cycle 3: ready
        check("rd_done_ready",   32'(bus.ready),   32'h1);
        check("rd_done_err",     32'(bus.err),     32'h0);
        check("rd_done_rdata",   bus.rdata,        32'hDEAD_BEEF);
        check("rd_done_psel",    32'(bus.PSEL),    32'h0);
        check("rd_done_penable", 32'(bus.PENABLE), 32'h0);
        tick();
        check("rd_after_ready", 32'(bus.ready), 32'h0);
        check("rd_after_rdata", bus.rdata,      32'hDEAD_BEEF);

        // ---- out of range: first address past the last slave
        start(1'b0, 32'h1000_4000, 32'h0);
        tick();
        bus.transfer = 1'b0;
        check("oor_hi_psel",  32'(bus.PSEL),  32'h0);
        check("oor_hi_ready", 32'(bus.ready), 32'h1);
        check("oor_hi_err",   32'(bus.err),   32'h1);
        check("oor_hi_rdata", bus.rdata,      32'h0);
        tick();
        check_idle_outputs("oor_hi_after");

        // ---- write to slave 3 with three wait states
        bus.PREADY = 4'b0111;
        start(1'b1, 32'h1000_3000, 32'h1234_5678);
        tick();                                     // cycle 1: SETUP
        bus.transfer = 1'b0;
        check("wr_setup_psel",    32'(bus.PSEL),    32'h8);
        check("wr_setup_penable", 32'(bus.PENABLE), 32'h0);
        check("wr_setup_pwrite",  32'(bus.PWRITE),  32'h1);
        check("wr_setup_pwdata",  bus.PWDATA,       32'h1234_5678);
        for (int c = 2; c <= 5; c++) begin          // cycles 2..5: ACCESS
            tick();
            check($sformatf("wr_acc%0d_psel", c),    32'(bus.PSEL),    32'h8);
            check($sformatf("wr_acc%0d_penable", c), 32'(bus.PENABLE), 32'h1);
            check($sformatf("wr_acc%0d_paddr", c),   bus.PADDR,        32'h1000_3000);
            check($sformatf("wr_acc%0d_pwdata", c),  bus.PWDATA,       32'h1234_5678);
            check($sformatf("wr_acc%0d_ready", c),   32'(bus.ready),   32'h0);
            if (c == 5) bus.PREADY = 4'b1000;
        end
        tick();                                     // cycle 6: ready
        bus.PREADY = 4'b0000;
        check("wr_done_ready", 32'(bus.ready), 32'h1);
        check("wr_done_err",   32'(bus.err),   32'h0);
        check("wr_done_rdata", bus.rdata,      32'h0);
        check("wr_done_psel",  32'(bus.PSEL),  32'h0);

        // ---- out of range: just below the window, after a nonzero rdata
        set_prdata(0, 32'h0BAD_F00D);
        bus.PREADY = 4'b0001;
        start(1'b0, 32'h1000_0000, 32'h0);
        tick();
        bus.transfer = 1'b0;
        tick();
        tick();
        check("pre_oor_lo_rdata", bus.rdata, 32'h0BAD_F00D);
        start(1'b0, 32'h0FFF_FFFC, 32'h0);
        tick();
        bus.transfer = 1'b0;
        check("oor_lo_psel",  32'(bus.PSEL),  32'h0);
        check("oor_lo_ready", 32'(bus.ready), 32'h1);
        check("oor_lo_err",   32'(bus.err),   32'h1);
        check("oor_lo_rdata", bus.rdata,      32'h0);
        tick();
        check_idle_outputs("oor_lo_after");

        // ---- slave 2 error, then back-to-back transfer to slave 0
        bus.PREADY  = 4'b0100;
        bus.PSLVERR = 4'b0100;
        start(1'b0, 32'h1000_2008, 32'h0);
        tick();                                     // cycle 1
        check("serr_setup_psel", 32'(bus.PSEL), 32'h4);
        tick();                                     // cycle 2
        check("serr_acc_penable", 32'(bus.PENABLE), 32'h1);
        tick();                                     // cycle 3: ready, new request held
        check("serr_ready", 32'(bus.ready), 32'h1);
        check("serr_err",   32'(bus.err),   32'h1);
        check("serr_rdata", bus.rdata,      32'h55AA_55AA);
        bus.PREADY  = 4'b0001;
        bus.PSLVERR = 4'b0000;
        start(1'b0, 32'h1000_0010, 32'h0);
        tick();                                     // cycle 4: SETUP of second transfer
        bus.transfer = 1'b0;
        check("b2b_setup_psel",    32'(bus.PSEL),    32'h1);
        check("b2b_setup_penable", 32'(bus.PENABLE), 32'h0);
        check("b2b_setup_paddr",   bus.PADDR,        32'h1000_0010);
        check("b2b_setup_ready",   32'(bus.ready),   32'h0);
        check("b2b_setup_err",     32'(bus.err),     32'h0);
        tick();
        tick();
        check("b2b_ready", 32'(bus.ready), 32'h1);
        check("b2b_err",   32'(bus.err),   32'h0);
        check("b2b_rdata", bus.rdata,      32'h0BAD_F00D);

        // ---- reset during ACCESS
        bus.PREADY = 4'b0000;
        start(1'b1, 32'h1000_1000, 32'h7777_8888);
        tick();
        bus.transfer = 1'b0;
        tick();
        check("rstmid_acc_penable", 32'(bus.PENABLE), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("rstmid");
        check("rstmid_paddr",  bus.PADDR,       32'h0);
        check("rstmid_pwdata", bus.PWDATA,      32'h0);
        check("rstmid_pwrite", 32'(bus.PWRITE), 32'h0);
        check("rstmid_rdata",  bus.rdata,       32'h0);
        bus.PREADY = 4'b1111;
        tick();
        check_idle_outputs("rstmid_after1");
        tick();
        check_idle_outputs("rstmid_after2");
        start(1'b0, 32'h1000_0ffc, 32'h0);
        tick();
        bus.transfer = 1'b0;
        check("post_rst_psel", 32'(bus.PSEL), 32'h1);
        tick();
        tick();
        check("post_rst_ready", 32'(bus.ready), 32'h1);
        check("post_rst_rdata", bus.rdata,      32'h0BAD_F00D);

`ifdef APB_TIMEOUT_EN
        // ---- slave 1 stuck: abort after four ACCESS cycles
        tick();
        bus.PREADY = 4'b1101;
        start(1'b0, 32'h1000_1000, 32'h0);
        tick();                                     // cycle 1
        bus.transfer = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            check($sformatf("to_acc%0d_penable", c), 32'(bus.PENABLE), 32'h1);
            check($sformatf("to_acc%0d_ready", c),   32'(bus.ready),   32'h0);
        end
        tick();                                     // cycle 6
        check("to_ready",   32'(bus.ready),   32'h1);
        check("to_err",     32'(bus.err),     32'h1);
        check("to_rdata",   bus.rdata,        32'h0);
        check("to_psel",    32'(bus.PSEL),    32'h0);
        check("to_penable", 32'(bus.PENABLE), 32'h0);

        // ---- PREADY rises in the limit cycle: normal completion
        tick();
        bus.PREADY = 4'b0000;
        start(1'b0, 32'h1000_1000, 32'h0);
        tick();
        bus.transfer = 1'b0;
        tick();
        tick();
        tick();
        tick();                                     // cycle 5: fourth ACCESS cycle
        bus.PREADY = 4'b0010;
        tick();
        check("to_race_ready", 32'(bus.ready), 32'h1);
        check("to_race_err",   32'(bus.err),   32'h0);
        check("to_race_rdata", bus.rdata,      32'hDEAD_BEEF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Parametrised bridge between the RV32I core's data port and an APB3 peripheral bus with `NUM_SLAVES` memory-mapped slaves. It replaces the fixed single-RAM data path in the MCU top for every address inside the peripheral window. It also adds:
- address decode,
- the APB SETUP/ACCESS state machine,
- wait-state stalling of the core,
- error reporting and an optional watchdog timeout.

## Interface
Parameters:
- `NUM_SLAVES`, 4 — number of APB slaves (1..16).
- `BASE_ADDR`, 32'h1000_0000 — start of the peripheral window; aligned to the full window size.
- `SLAVE_SIZE_LOG2`, 12 — log2 of the bytes per slave region.
- `TIMEOUT`, 255 — ACCESS cycles before abort; only used with `APB_TIMEOUT_EN`.

Ports:
- `clk` in 1 — the single clock.
- `reset` in 1 — synchronous, active-high.
- `transfer` in 1 — core request; sampled only in IDLE.
- `write` in 1 — 1 = store, 0 = load.
- `addr` in 32 — byte address.
- `wdata` in 32 — store data.
- `rdata` out 32 — load data; valid while `ready` = 1.
- `ready` out 1 — one-cycle completion pulse.
- `err` out 1 — asserted with `ready` on a failed transfer.
- `PADDR` out 32
- `PWDATA` out 32
- `PWRITE` out 1
- `PSEL` out `NUM_SLAVES` — one-hot.
- `PENABLE` out 1
- `PRDATA` in 32*`NUM_SLAVES` — slave i occupies bits [32i+31:32i].
- `PREADY` in `NUM_SLAVES`
- `PSLVERR` in `NUM_SLAVES`

## Operation
- States: IDLE, SETUP, ACCESS.
- **IDLE**
  - On `transfer` = 1, latch `addr`, `wdata` and `write`, and decode the slave index as (`addr` − `BASE_ADDR`) >> `SLAVE_SIZE_LOG2`.
  - In range: go to SETUP.
  - Out of range (below `BASE_ADDR`, or at/above `BASE_ADDR` + (`NUM_SLAVES` << `SLAVE_SIZE_LOG2`)): no PSEL; next cycle `ready` = 1, `err` = 1, `rdata` = 0; stay in IDLE.
- **SETUP**
  - `PSEL`[idx] = 1, `PENABLE` = 0.
  - `PADDR`, `PWDATA` and `PWRITE` come from the latched values.
  - Always go to ACCESS after one cycle.
- **ACCESS**
  - `PSEL`[idx] = 1, `PENABLE` = 1.
  - While `PREADY`[idx] = 0: hold all APB outputs stable.
  - When `PREADY`[idx] = 1:
    - capture `PRDATA` slice idx into `rdata`; writes capture 0 instead;
    - capture `PSLVERR`[idx] into `err`;
    - go to IDLE, and pulse `ready` in the following cycle.
- `PREADY`/`PSLVERR`/`PRDATA` of non-selected slaves are ignored.
- `transfer` outside IDLE is ignored; the core holds its request until `ready`.
- A `transfer` asserted in the same cycle as the `ready` pulse (state IDLE) is accepted, giving back-to-back transfers.
- `PADDR` is the full byte address. `PWDATA` is passed through unmodified; byte-lane formatting is done upstream.

## Timing
- Reset values:
  - state IDLE;
  - `PSEL` = 0, `PENABLE` = 0, `PWRITE` = 0;
  - `PADDR` = 0, `PWDATA` = 0;
  - `rdata` = 0, `ready` = 0, `err` = 0.
- Reset mid-transfer aborts the transfer:
  - `PSEL`/`PENABLE` are 0 from the first cycle after the reset edge;
  - no `ready` pulse is produced for the aborted transfer.
- Zero-wait latency, with `transfer` sampled at edge 0:
  - SETUP during cycle 1;
  - ACCESS during cycle 2;
  - `ready` during cycle 3.
- Each wait state adds one cycle.
- Decode error: `ready` one cycle after `transfer` is sampled.
- `ready` and `err` are registered and high for exactly one cycle. `rdata` holds its value until the next completion.

## Configuration
Macro: `APB_TIMEOUT_EN`.

Defined:
- An 8-bit+ counter clears on entry to ACCESS and increments each ACCESS cycle while `PREADY`[idx] = 0.
- When the count reaches `TIMEOUT`, the transfer ends:
  - next cycle `PSEL` = 0 and `PENABLE` = 0, state IDLE;
  - `ready` = 1, `err` = 1, `rdata` = 0.
- If `PREADY` rises in the same cycle the limit is reached, `PREADY` wins and the transfer completes normally.

Undefined:
- No counter is built; ACCESS waits indefinitely.

## Test plan
- **Zero-wait read:** write=0, addr 0x1000_1004, slave 1 `PRDATA` 0xDEAD_BEEF, `PREADY` = 1 → `PSEL` = 4'b0010, `PADDR` 0x1000_1004; `ready` in cycle 3 with `rdata` 0xDEAD_BEEF, `err` 0.
- **Write with wait states:** write to 0x1000_3000, wdata 0x1234_5678, slave 3 `PREADY` low 3 cycles → `PWDATA`/`PADDR`/`PSEL` = 4'b1000 stable through ACCESS; `ready` in cycle 6.
- **Out-of-range address:** 0x1000_4000 and 0x0FFF_FFFC → no `PSEL` ever; `ready` = 1, `err` = 1, `rdata` 0 one cycle later.
- **Slave error plus back-to-back:** slave 2 returns `PSLVERR` = 1 → `err` = 1 with `ready`; a new `transfer` held through the `ready` cycle starts SETUP the next cycle.
- **Reset mid-transfer:** reset asserted during ACCESS → all outputs at reset values the next cycle, no `ready` pulse; a transfer issued after reset completes normally.
- **Timeout** (`APB_TIMEOUT_EN`, `TIMEOUT` = 4, `PREADY` stuck low) → abort with `err` = 1. With `PREADY` rising in the limit cycle → normal completion, `err` = 0.
